// File: rtl/instr_boot_loader.sv
// Byte-stream loader for the CPU instruction memory: a 16-bit count, big-endian words and an XOR checksum.
// The CPU stays in reset until the whole image is written and the checksum matches.
module instr_boot_loader #(
   parameter int          MAX_WORDS = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        initialize,
   output logic [31:0] instruction_initialize_data,
   output logic [31:0] instruction_initialize_address,
   output logic        cpu_rst,
   output logic        done,
   output logic        error,
   output logic [2:0]  o_dbg_state
);

   typedef enum logic [2:0] {
      HDR_HI  = 3'd0,
      HDR_LO  = 3'd1,
      PAYLOAD = 3'd2,
      WRITE   = 3'd3,
      CHECK   = 3'd4,
      DONE    = 3'd5,
      ERROR   = 3'd6
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_count_hi;
   logic [15:0] r_words_left;
   logic [1:0]  r_byte_idx;
   logic [23:0] r_shift;
   logic [7:0]  r_xor;
   logic [31:0] r_data;
   logic [31:0] r_addr;
   logic        w_accept;
   logic [15:0] w_count;

   // Handshake: a byte moves on a rising edge exactly when byte_valid && byte_ready.
   assign w_accept = byte_valid && byte_ready;
   assign w_count  = {r_count_hi, byte_data};

   assign instruction_initialize_data    = r_data;
   assign instruction_initialize_address = r_addr;
   assign o_dbg_state                    = r_state;

   always_comb begin
      w_next     = r_state;
      byte_ready = 1'b0;
      initialize = 1'b0;
      cpu_rst    = 1'b1;
      done       = 1'b0;
      error      = 1'b0;
      case (r_state)
         HDR_HI: begin
            byte_ready = 1'b1;
            if (w_accept) w_next = HDR_LO;
         end
         HDR_LO: begin
            byte_ready = 1'b1;
            if (w_accept) begin
               if (w_count > 16'(MAX_WORDS)) w_next = ERROR;
               else if (w_count == 16'd0)    w_next = CHECK;
               else                          w_next = PAYLOAD;
            end
         end
         PAYLOAD: begin
            byte_ready = 1'b1;
            if (w_accept && (r_byte_idx == 2'd3)) w_next = WRITE;
         end
         WRITE: begin
            initialize = 1'b1;
            w_next     = (r_words_left > 16'd1) ? PAYLOAD : CHECK;
         end
         CHECK: begin
            byte_ready = 1'b1;
            if (w_accept) w_next = (byte_data == r_xor) ? DONE : ERROR;
         end
         DONE: begin
            cpu_rst = 1'b0;
            done    = 1'b1;
         end
         ERROR: begin
            error = 1'b1;
         end
         default: w_next = HDR_HI;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= HDR_HI;
         r_count_hi   <= 8'd0;
         r_words_left <= 16'd0;
         r_byte_idx   <= 2'd0;
         r_shift      <= 24'd0;
         r_xor        <= 8'd0;
         r_data       <= 32'd0;
         r_addr       <= BASE_ADDR;
      end else begin
         r_state <= w_next;
         case (r_state)
            HDR_HI: if (w_accept) begin
               r_count_hi <= byte_data;
               r_xor      <= r_xor ^ byte_data;
            end
            HDR_LO: if (w_accept) begin
               r_words_left <= w_count;
               r_xor        <= r_xor ^ byte_data;
            end
            PAYLOAD: if (w_accept) begin
               // MSB-first: the first byte of a word ends up in [31:24].
               r_shift    <= {r_shift[15:0], byte_data};
               r_byte_idx <= r_byte_idx + 2'd1;
               r_xor      <= r_xor ^ byte_data;
               if (r_byte_idx == 2'd3) r_data <= {r_shift, byte_data};
            end
            WRITE: begin
               r_addr       <= r_addr + 32'd4;
               r_words_left <= r_words_left - 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/instr_boot_loader.md
Name: instr_boot_loader

Overview:
- Upstream loader for the single-cycle CPU's instruction memory.
- Consumes a byte stream: a 16-bit word count, then big-endian 32-bit instructions, then an XOR checksum byte.
- Drives the CPU's `initialize`, `instruction_initialize_data` and `instruction_initialize_address` inputs, one write per word.
- Holds the CPU in reset via `cpu_rst` until the image loads and the checksum matches.

Parameters:
- MAX_WORDS, 64, largest accepted word count; a larger header count is an error.
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction; each following word is +4.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- byte_valid  input  1  byte_data holds a valid byte
- byte_data  input  8  incoming stream byte
- byte_ready  output  1  loader can accept a byte this cycle
- initialize  output  1  instruction-memory write strobe, one cycle per word
- instruction_initialize_data  output  32  assembled instruction word
- instruction_initialize_address  output  32  byte address for the write
- cpu_rst  output  1  reset to the CPU; high until the load completes
- done  output  1  load completed with a good checksum (sticky)
- error  output  1  oversize count or checksum mismatch (sticky)

Behaviour:
- Only synchronous reset exists; no async paths.
- Reset values, taking effect at the first edge with rst=1:
  - state=HDR_HI, initialize=0, instruction_initialize_data=0, instruction_initialize_address=BASE_ADDR.
  - cpu_rst=1, done=0, error=0.
  - Internal: word counter=0, byte index=0, running xor=0.
- Byte handshake:
  - A byte is accepted at a rising edge when byte_valid && byte_ready.
  - byte_valid may drop at any time; the loader has no timeout.
- byte_ready is combinational from state:
  - 1 in HDR_HI, HDR_LO, PAYLOAD, CHECK.
  - 0 in WRITE, DONE, ERROR.
- Running xor: every accepted header and payload byte is XORed in. The checksum byte itself is not.
- HDR_HI: accept byte → count[15:8]; go to HDR_LO.
- HDR_LO: accept byte → count[7:0]. Next state:
  - full count > MAX_WORDS → ERROR.
  - count == 0 → CHECK.
  - otherwise → PAYLOAD.
- PAYLOAD:
  - Bytes shift in MSB first: the first byte accepted lands in [31:24].
  - On the 4th byte, instruction_initialize_data takes the full word (registered) and the state goes to WRITE.
- WRITE, exactly one cycle:
  - initialize=1; data and address are stable all cycle.
  - Next edge: initialize=0, address += 4 (32-bit wrap), words_left -= 1.
  - Then → PAYLOAD if words_left > 0, else → CHECK.
  - First write is at BASE_ADDR; word k is written at BASE_ADDR + 4k.
- Write latency: initialize rises on the edge that accepts the 4th byte of a word. It is visible the cycle after acceptance.
- CHECK: accept one byte.
  - byte == running xor → DONE: done=1 and cpu_rst=0 from the next cycle.
  - otherwise → ERROR: error=1, cpu_rst stays 1.
- DONE and ERROR are terminal until rst.
  - byte_ready=0; incoming bytes are ignored.
  - initialize stays 0.
- initialize is never 1 outside WRITE.
- cpu_rst is 1 in every state except DONE.
- Reset mid-load (any state, including WRITE):
  - Loader returns to the reset state; the next edge's initialize=0.
  - Words already written stay in memory; a reload overwrites them.
- Simultaneous rst and byte_valid: rst wins and the byte is dropped.
- Count 0 with a correct checksum (0x00) → DONE with no writes.

Test Plan:
- Normal load: stream 00 02 20 01 00 05 AC 01 00 00 8B, byte_valid held high →
  - initialize pulses twice: data 32'h2001_0005 @ addr 0, then 32'hAC01_0000 @ addr 4.
  - byte_ready=0 during each pulse.
  - done=1, cpu_rst=0 the cycle after 8B is accepted.
- Bad checksum: same stream ending 8A →
  - both writes still occur.
  - error=1, cpu_rst stays 1, done=0, byte_ready=0 afterwards.
- Zero count: 00 00 00 → no initialize pulse, done=1, cpu_rst=0.
- Oversize: 00 41 with MAX_WORDS=64 → error=1 the cycle after the 2nd byte, no writes, later bytes ignored.
- Gaps: normal load with byte_valid toggled 1,0,0,1 between bytes → identical writes and final state.
- Reset mid-word: rst after 2 payload bytes, then the full normal stream →
  - initialize=0 during reset.
  - Writes restart at address 0 and finish with done=1.
